// File: rtl/vr_wheel_gen.sv
// Crank-wheel simulator: generates a VR/Hall tooth train with a missing-tooth
// sync gap, a revolution sync pulse and a half-speed cam phase signal.
module vr_wheel_gen #(
  parameter int TEETH   = 60,
  parameter int MISSING = 2,
  parameter int CNT_W   = 16,
  parameter int PRE_W   = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [PRE_W-1:0]         presc,
  input  logic                     period_we,
  input  logic [CNT_W-1:0]         period_in,
  output logic                     vr_out,
  output logic [$clog2(TEETH)-1:0] tooth_idx,
  output logic                     sync,
  output logic                     cam_out
);

  localparam int IDX_W = $clog2(TEETH);
  // Wide enough to hold P*(MISSING+1)-1 without truncation.
  localparam int TOP_W = CNT_W + $clog2(MISSING + 2);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(TEETH - MISSING - 1);
  localparam logic [CNT_W-1:0] RST_PERIOD = CNT_W'(64);
  localparam logic [TOP_W-1:0] GAP_MULT   = TOP_W'(MISSING + 1);

  logic [PRE_W-1:0] pcnt_reg, pcnt_next;
  logic [TOP_W-1:0] tckc_reg, tckc_next;
  logic [IDX_W-1:0] tooth_idx_reg, tooth_idx_next;
  logic             vr_out_reg, vr_out_next;
  logic             sync_reg, sync_next;
  logic             cam_out_reg, cam_out_next;
  logic [CNT_W-1:0] shadow_reg, shadow_next;
  logic [CNT_W-1:0] act_period_reg, act_period_next;

  logic [CNT_W-1:0] p_eff;
  logic [TOP_W-1:0] top;
  logic             tick, tooth_end, wrap;

  always_comb begin
    p_eff     = (act_period_reg < CNT_W'(2)) ? CNT_W'(2) : act_period_reg;
    top       = (tooth_idx_reg == '0) ? (TOP_W'(p_eff) * GAP_MULT - TOP_W'(1))
                                      : (TOP_W'(p_eff) - TOP_W'(1));
    tick      = en && (pcnt_reg == presc);
    tooth_end = tick && (tckc_reg == top);
    wrap      = tooth_end && (tooth_idx_reg == LAST_IDX);
  end

  always_comb begin
    pcnt_next       = pcnt_reg;
    tckc_next       = tckc_reg;
    tooth_idx_next  = tooth_idx_reg;
    vr_out_next     = vr_out_reg;
    sync_next       = 1'b0;
    cam_out_next    = cam_out_reg;
    shadow_next     = shadow_reg;
    act_period_next = act_period_reg;

    if (period_we)
      shadow_next = period_in;

    // The >= also recovers immediately when presc is lowered below pcnt.
    if (en)
      pcnt_next = (pcnt_reg >= presc) ? '0 : pcnt_reg + PRE_W'(1);

    if (tooth_end) begin
      tckc_next      = '0;
      vr_out_next    = 1'b0;
      tooth_idx_next = wrap ? '0 : tooth_idx_reg + IDX_W'(1);
    end else if (tick) begin
      tckc_next = tckc_reg + TOP_W'(1);
      if (tckc_reg == (top >> 1))
        vr_out_next = 1'b1;
    end

    // Period changes only land on a revolution boundary.
    if (wrap) begin
      sync_next       = 1'b1;
      cam_out_next    = ~cam_out_reg;
      act_period_next = shadow_reg;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcnt_reg       <= '0;
      tckc_reg       <= '0;
      tooth_idx_reg  <= '0;
      vr_out_reg     <= 1'b0;
      sync_reg       <= 1'b0;
      cam_out_reg    <= 1'b0;
      shadow_reg     <= RST_PERIOD;
      act_period_reg <= RST_PERIOD;
    end else begin
      pcnt_reg       <= pcnt_next;
      tckc_reg       <= tckc_next;
      tooth_idx_reg  <= tooth_idx_next;
      vr_out_reg     <= vr_out_next;
      sync_reg       <= sync_next;
      cam_out_reg    <= cam_out_next;
      shadow_reg     <= shadow_next;
      act_period_reg <= act_period_next;
    end
  end

  assign vr_out    = vr_out_reg;
  assign tooth_idx = tooth_idx_reg;
  assign sync      = sync_reg;
  assign cam_out   = cam_out_reg;

endmodule

// File: tb/tb_vr_wheel_gen.sv
// Directed bench for vr_wheel_gen: table of wheel configurations measured over
// one revolution, plus sequences for period update, enable pause and reset.
module tb_vr_wheel_gen;
  localparam int TEETH   = 60;
  localparam int MISSING = 2;
  localparam int CNT_W   = 16;
  localparam int PRE_W   = 8;
  localparam int IDX_W   = $clog2(TEETH);

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic [PRE_W-1:0] presc;
  logic             period_we;
  logic [CNT_W-1:0] period_in;
  logic             vr_out;
  logic [IDX_W-1:0] tooth_idx;
  logic             sync;
  logic             cam_out;

  vr_wheel_gen #(
    .TEETH(TEETH), .MISSING(MISSING), .CNT_W(CNT_W), .PRE_W(PRE_W)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .presc(presc),
    .period_we(period_we), .period_in(period_in),
    .vr_out(vr_out), .tooth_idx(tooth_idx), .sync(sync), .cam_out(cam_out)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  typedef struct {
    int presc;
    int period;
    int gap;
    int gap_hi;
    int tooth;
    int tooth_hi;
    int rev;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end else begin
      $display("[TB] ok %s: %0d", name, act);
    end
  endtask

  task automatic timeout(input string name);
    tests++;
    fails++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  // Leaves the caller at the release negedge.
  task automatic do_reset(input int p);
    @(negedge clk);
    rst = 1'b1; en = 1'b1; period_we = 1'b0; presc = PRE_W'(p);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic load_period(input int p);
    period_in = CNT_W'(p);
    period_we = 1'b1;
    @(negedge clk);
    period_we = 1'b0;
  endtask

  task automatic wait_sync(input string name, input int limit);
    int n = 0;
    @(negedge clk);
    while (!sync && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (!sync) timeout(name);
  endtask

  task automatic wait_idx(input string name, input int idx, input int limit);
    int n = 0;
    while (int'(tooth_idx) != idx && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (int'(tooth_idx) != idx) timeout(name);
  endtask

  task automatic tooth_len(input string name, input int idx, input int limit, output int len);
    len = 0;
    wait_idx(name, idx, limit);
    while (int'(tooth_idx) == idx && len < limit) begin
      @(negedge clk);
      len++;
    end
  endtask

  // Starts at a sync (or reset-release) state and runs to the next sync.
  task automatic measure_rev(input string name, input int limit,
                             output int gap, output int gap_hi,
                             output int tooth, output int tooth_hi,
                             output int rev, output int sync_after);
    gap = 0; gap_hi = 0; tooth = 0; tooth_hi = 0; rev = 0; sync_after = 0;
    do begin
      if (tooth_idx == 0) begin
        gap++;
        gap_hi += int'(vr_out);
      end else if (tooth_idx == 1) begin
        tooth++;
        tooth_hi += int'(vr_out);
      end
      @(negedge clk);
      rev++;
      if (rev == 1) sync_after = int'(sync);
    end while (!sync && rev < limit);
    if (!sync) timeout(name);
  endtask

  initial begin
    int g, gh, t, th, r, sa, n, hold_err;
    bit paused;

    vecs[0] = '{presc: 0, period: 16, gap: 48,  gap_hi: 24, tooth: 16, tooth_hi: 8,  rev: 960};
    vecs[1] = '{presc: 0, period: 0,  gap: 6,   gap_hi: 3,  tooth: 2,  tooth_hi: 1,  rev: 120};
    vecs[2] = '{presc: 0, period: 1,  gap: 6,   gap_hi: 3,  tooth: 2,  tooth_hi: 1,  rev: 120};
    vecs[3] = '{presc: 1, period: 5,  gap: 30,  gap_hi: 14, tooth: 10, tooth_hi: 4,  rev: 600};
    vecs[4] = '{presc: 0, period: 64, gap: 192, gap_hi: 96, tooth: 64, tooth_hi: 32, rev: 3840};

    rst = 1'b1; en = 1'b0; presc = '0; period_we = 1'b0; period_in = '0;
    #1;
    check("reset tooth_idx", int'(tooth_idx), 0);
    check("reset vr_out", int'(vr_out), 0);
    check("reset sync", int'(sync), 0);
    check("reset cam_out", int'(cam_out), 0);

    for (int i = 0; i < 5; i++) begin
      do_reset(vecs[i].presc);
      load_period(vecs[i].period);
      wait_sync($sformatf("v%0d first sync", i), 3840 * (vecs[i].presc + 1) + 50);
      check($sformatf("v%0d cam after 1st sync", i), int'(cam_out), 1);
      measure_rev($sformatf("v%0d rev", i), vecs[i].rev + 50, g, gh, t, th, r, sa);
      check($sformatf("v%0d gap len", i), g, vecs[i].gap);
      check($sformatf("v%0d gap high", i), gh, vecs[i].gap_hi);
      check($sformatf("v%0d tooth len", i), t, vecs[i].tooth);
      check($sformatf("v%0d tooth high", i), th, vecs[i].tooth_hi);
      check($sformatf("v%0d rev len", i), r, vecs[i].rev);
      check($sformatf("v%0d sync width", i), sa, 0);
      check($sformatf("v%0d cam after 2nd sync", i), int'(cam_out), 0);
    end

    // P=16 wheel; pause enable for 100 clk while tooth 10 is high.
    do_reset(0);
    load_period(16);
    wait_sync("A first sync", 3900);
    wait_idx("A idx10", 10, 400);
    n = 0; paused = 1'b0; hold_err = 0;
    while (tooth_idx == 10 && n < 400) begin
      if (vr_out && !paused) begin
        paused = 1'b1;
        en = 1'b0;
        repeat (100) begin
          @(negedge clk);
          n++;
          if (vr_out !== 1'b1 || tooth_idx != 10 || sync !== 1'b0) hold_err++;
        end
        en = 1'b1;
      end else begin
        @(negedge clk);
        n++;
      end
    end
    check("pause hold errors", hold_err, 0);
    check("pause tooth10 len", n, 116);

    // Mid-revolution period request must not disturb the running revolution.
    wait_idx("A idx20", 20, 400);
    load_period(32);
    tooth_len("A tooth21", 21, 400, t);
    check("midrev tooth21 len", t, 16);
    tooth_len("A tooth57", 57, 1000, t);
    check("midrev tooth57 len", t, 16);
    check("midrev sync at wrap", int'(sync), 1);
    measure_rev("A rev32", 2000, g, gh, t, th, r, sa);
    check("p32 gap len", g, 96);
    check("p32 tooth len", t, 32);
    check("p32 rev len", r, 1920);

    // Write landing in the wrap cycle: old shadow goes active, new one next time.
    wait_idx("B idx57", 57, 2000);
    repeat (31) @(negedge clk);
    load_period(8);
    check("wrap-we sync", int'(sync), 1);
    measure_rev("B rev", 2000, g, gh, t, th, r, sa);
    check("wrap-we still p32 rev", r, 1920);
    check("wrap-we still p32 tooth", t, 32);
    measure_rev("B rev8", 600, g, gh, t, th, r, sa);
    check("p8 gap len", g, 24);
    check("p8 tooth len", t, 8);
    check("p8 tooth high", th, 4);
    check("p8 rev len", r, 480);

    // Asynchronous reset at tooth 40.
    wait_idx("C idx40", 40, 600);
    #2;
    rst = 1'b1;
    #1;
    check("async rst tooth_idx", int'(tooth_idx), 0);
    check("async rst vr_out", int'(vr_out), 0);
    check("async rst sync", int'(sync), 0);
    check("async rst cam_out", int'(cam_out), 0);
    @(negedge clk);
    rst = 1'b0;
    measure_rev("C post-reset rev", 3900, g, gh, t, th, r, sa);
    check("post-rst gap len", g, 192);
    check("post-rst tooth len", t, 64);
    check("post-rst clk to sync", r, 3840);

    // presc=3 at the reset period.
    do_reset(3);
    measure_rev("D presc3 rev", 15400, g, gh, t, th, r, sa);
    check("presc3 gap len", g, 768);
    check("presc3 tooth len", t, 256);
    check("presc3 tooth high", th, 128);
    check("presc3 clk to sync", r, 15360);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/vr_wheel_gen.md
VR_WHEEL_GEN -- requirements
Module: vr_wheel_gen

Interface
REQ-001 Parameter TEETH, default 60: nominal tooth positions per revolution.
REQ-002 Parameter MISSING, default 2: missing teeth forming the sync gap; legal range 0..TEETH-2.
REQ-003 Parameter CNT_W, default 16: width of the tooth period and tick counter.
REQ-004 Parameter PRE_W, default 8: prescaler width.
REQ-005 clk  input  1  single clock; all state on rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 en  input  1  run enable; low freezes all counters and holds outputs.
REQ-008 presc  input  PRE_W  tick divider; one tick every presc+1 clk cycles.
REQ-009 period_we  input  1  one-cycle strobe loading period_in into the shadow register.
REQ-010 period_in  input  CNT_W  requested tooth period in ticks.
REQ-011 vr_out  output  1  simulated VR/Hall tooth signal.
REQ-012 tooth_idx  output  $clog2(TEETH)  current physical tooth, 0..TEETH-MISSING-1.
REQ-013 sync  output  1  one-clk pulse when tooth_idx wraps to 0.
REQ-014 cam_out  output  1  half-speed cam phase, toggles once per revolution.

Function
REQ-015 Prescaler: pcnt counts 0..presc while en=1, then returns to 0; tick = (pcnt==presc) && en; presc=0 gives a tick every clk.
REQ-016 Tick counter tckc advances only on tick; at tckc==top it clears to 0 and the tooth ends.
REQ-017 Active period P = max(act_period, 2); normal tooth top = P-1.
REQ-018 Tooth 0 is the gap tooth: top = P*(MISSING+1)-1, computed in CNT_W+$clog2(MISSING+2) bits with no truncation; MISSING=0 gives a uniform wheel.
REQ-019 On tooth end, vr_out is registered low; when tckc==(top>>1) on a tick, vr_out is registered high (visible the next clk).
REQ-020 On tooth end, tooth_idx increments; from TEETH-MISSING-1 it wraps to 0.
REQ-021 On the wrap to 0, sync pulses high for exactly one clk, and cam_out toggles in the same cycle.
REQ-022 period_we loads period_in into shadow; the shadow is copied to act_period only in the wrap cycle, so a running revolution never changes period mid-way.
REQ-023 period_we in the same cycle as a wrap: the wrap copies the old shadow value; the new value applies at the next wrap.
REQ-024 en=0: pcnt, tckc, tooth_idx, vr_out, cam_out hold; sync=0; period_we still loads the shadow.
REQ-025 A presc change takes effect immediately; if pcnt>presc, pcnt clears to 0 on the next clk.
REQ-026 Revolution length = TEETH*P ticks: (TEETH-MISSING-1)*P normal teeth plus (MISSING+1)*P gap-tooth ticks.

Reset
REQ-027 rst=1 asynchronously clears pcnt, tckc, tooth_idx, vr_out, sync and cam_out to 0.
REQ-028 Reset loads shadow and act_period with 64 (the legacy test-wheel period).
REQ-029 Reset mid-tooth, mid-gap or mid-update aborts the operation; the first tooth after release is tooth 0 (the gap tooth).
REQ-030 Reset assertion and release carry no clk-alignment requirement beyond ordinary synchronous release.

Verification
REQ-031 Defaults, presc=0, en=1, period 16 loaded and one wrap elapsed -> vr_out period 16 clk, high 8 clk; gap tooth 48 clk; sync every 960 clk; cam_out period 1920 clk.
REQ-032 presc=3 with period 64 (reset value) -> normal tooth 256 clk; gap tooth 768 clk; sync every 15360 clk.
REQ-033 period_we with 32 at tooth 20 -> teeth 21..57 remain 16; after the next sync, teeth are 32 and the gap is 96.
REQ-034 en dropped for 100 clk at tooth 10 mid-high -> vr_out, tooth_idx and tckc are unchanged over the pause and resume with no lost or extra tick.
REQ-035 period_in=0, then 1 -> both behave as P=2: tooth 2 ticks, gap 6 ticks (MISSING=2); no lock-up.
REQ-036 rst pulsed at tooth 40 -> all outputs 0 within the same cycle; after release, tooth 0 is a 192-tick gap at P=64 and sync occurs at the end of tooth 57.
